// File: rtl/regfile_scoreboard_if.sv
// Bus interface for regfile_scoreboard.
// Signal suffixes are relative to the register file: *_i are driven into it and *_o are driven by it.
//   master : decode/writeback side. Drives addresses, write ports and issue; receives read data/busy.
//   slave  : register file side.
// Signals: rs1/rs2 read address, data and busy; W0 (ALU) and W1 (long-latency) write ports;
// issue/issue_rd to mark a pending producer; busy_cnt_o is the number of busy registers.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            w0_en_i;
  logic [AW-1:0]   w0_addr_i;
  logic [XLEN-1:0] w0_data_i;
  logic            w1_en_i;
  logic [AW-1:0]   w1_addr_i;
  logic [XLEN-1:0] w1_data_i;
  logic            issue_i;
  logic [AW-1:0]   issue_rd_i;
  logic [AW:0]     busy_cnt_o;

  modport master (
    output rs1_addr_i, rs2_addr_i,
    output w0_en_i, w0_addr_i, w0_data_i,
    output w1_en_i, w1_addr_i, w1_data_i,
    output issue_i, issue_rd_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, busy_cnt_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i,
    input  w0_en_i, w0_addr_i, w0_data_i,
    input  w1_en_i, w1_addr_i, w1_data_i,
    input  issue_i, issue_rd_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-write register file with a per-register busy scoreboard.
// Two combinational read ports, W0 (ALU) and W1 (long-latency) write ports; W1 wins on collision.
// A busy bit per register is set by issue and cleared by W1; set wins over clear.
// Register 0 is hardwired to zero and never busy.
// Ports:
//   clk_i : clock, all state updates on posedge
//   rst_i : asynchronous active-high reset, clears data, busy bits and busy count
//   rf    : regfile_scoreboard_if.slave bus (read ports, write ports, issue, busy count)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data (W1 over W0) to the
// read ports and to show a register as not busy while W1 is writing it (unless also re-issued).
module regfile_scoreboard #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  regfile_scoreboard_if.slave rf
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [AW:0]     r_busy_cnt;

  logic [NREG-1:0] w_busy_d;
  logic [AW:0]     w_busy_cnt_d;
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];
  logic            w_rbusy [2];

  // Next busy vector: a new issue supersedes a completing W1 on the same register.
  always_comb begin
    w_busy_d = r_busy;
    w_busy_d[0] = 1'b0;
    for (int i = 1; i < int'(NREG); i++) begin
      if (rf.issue_i && rf.issue_rd_i == AW'(i)) begin
        w_busy_d[i] = 1'b1;
      end else if (rf.w1_en_i && rf.w1_addr_i == AW'(i)) begin
        w_busy_d[i] = 1'b0;
      end
    end
  end

  // Count is the population of the updated vector, so it cannot drift or wrap.
  always_comb begin
    w_busy_cnt_d = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      w_busy_cnt_d = w_busy_cnt_d + (AW + 1)'(w_busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_d;
      r_busy_cnt <= w_busy_cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (rf.w0_en_i && rf.w0_addr_i != '0) begin
        r_regs[rf.w0_addr_i] <= rf.w0_data_i;
      end
      // Later assignment gives W1 priority over W0.
      if (rf.w1_en_i && rf.w1_addr_i != '0) begin
        r_regs[rf.w1_addr_i] <= rf.w1_data_i;
      end
    end
  end

  assign w_raddr[0] = rf.rs1_addr_i;
  assign w_raddr[1] = rf.rs2_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_regs[w_raddr[p]];
      w_rbusy[p] = r_busy[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (rf.w1_en_i && rf.w1_addr_i == w_raddr[p]) begin
        w_rdata[p] = rf.w1_data_i;
        if (!(rf.issue_i && rf.issue_rd_i == w_raddr[p])) begin
          w_rbusy[p] = 1'b0;
        end
      end else if (rf.w0_en_i && rf.w0_addr_i == w_raddr[p]) begin
        w_rdata[p] = rf.w0_data_i;
      end
`endif
      if (w_raddr[p] == '0) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end
    end
  end

  assign rf.rs1_data_o = w_rdata[0];
  assign rf.rs2_data_o = w_rdata[1];
  assign rf.rs1_busy_o = w_rbusy[0];
  assign rf.rs2_busy_o = w_rbusy[1];
  assign rf.busy_cnt_o = r_busy_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG)) rf ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rf   (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0_en;
    logic [4:0]  w0_addr;
    logic [31:0] w0_data;
    logic        w1_en;
    logic [4:0]  w1_addr;
    logic [31:0] w1_data;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic        exp_b1;
    logic        exp_b2;
    logic [5:0]  exp_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic idle();
    rf.w0_en_i = 1'b0;
    rf.w1_en_i = 1'b0;
    rf.issue_i = 1'b0;
  endtask

  task automatic check_reads(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic b1, input logic b2, input logic [5:0] cnt);
    check({tag, " rs1_data"}, rf.rs1_data_o, e1);
    check({tag, " rs2_data"}, rf.rs2_data_o, e2);
    check({tag, " rs1_busy"}, {31'b0, rf.rs1_busy_o}, {31'b0, b1});
    check({tag, " rs2_busy"}, {31'b0, rf.rs2_busy_o}, {31'b0, b2});
    check({tag, " busy_cnt"}, {26'b0, rf.busy_cnt_o}, {26'b0, cnt});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //           w0en a   data           w1en a   data           iss rd  rs1 rs2 exp1          exp2          b1 b2 cnt
    vecs[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[1]  = '{1, 5'd7, 32'h1,        1, 5'd7, 32'h2,        0, 5'd0, 7, 5, 32'h2,        32'hDEADBEEF, 0, 0, 0};
    vecs[2]  = '{1, 5'd0, 32'hAAAA,     1, 5'd0, 32'hBBBB,     1, 5'd0, 0, 7, 32'h0,        32'h2,        0, 0, 0};
    vecs[3]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 9, 0, 32'h0,        32'h0,        1, 0, 1};
    vecs[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 9, 5, 32'h0,        32'hDEADBEEF, 1, 0, 1};
    vecs[5]  = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h55,       0, 5'd0, 9, 9, 32'h55,       32'h55,       0, 0, 0};
    vecs[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 9, 0, 32'h55,       32'h0,        1, 0, 1};
    vecs[7]  = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h66,       1, 5'd9, 9, 0, 32'h66,       32'h0,        1, 0, 1};
    vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 9, 0, 32'h66,       32'h0,        1, 0, 1};
    vecs[9]  = '{0, 5'd0, 32'h0,        1, 5'd3, 32'h77,       0, 5'd0, 3, 9, 32'h77,       32'h66,       0, 1, 1};
    vecs[10] = '{0, 5'd0, 32'h0,        1, 5'd9, 32'h88,       0, 5'd0, 9, 3, 32'h88,       32'h77,       0, 0, 0};
    vecs[11] = '{1, 5'd4, 32'h11,       0, 5'd0, 32'h0,        1, 5'd4, 4, 0, 32'h11,       32'h0,        1, 0, 1};
    vecs[12] = '{1, 5'd4, 32'h22,       0, 5'd0, 32'h0,        0, 5'd0, 4, 3, 32'h22,       32'h77,       1, 0, 1};
    vecs[13] = '{0, 5'd0, 32'h0,        1, 5'd4, 32'h33,       0, 5'd0, 4, 0, 32'h33,       32'h0,        0, 0, 0};

    // Reset state
    rst = 1'b1;
    idle();
    rf.w0_addr_i = '0; rf.w0_data_i = '0; rf.w1_addr_i = '0; rf.w1_data_i = '0;
    rf.issue_rd_i = '0; rf.rs1_addr_i = 5'd5; rf.rs2_addr_i = 5'd9;
    repeat (2) @(posedge clk);
    #1;
    check_reads("reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: drive one cycle of writes/issue, then read stored state after the edge.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rf.w0_en_i = vecs[i].w0_en; rf.w0_addr_i = vecs[i].w0_addr; rf.w0_data_i = vecs[i].w0_data;
      rf.w1_en_i = vecs[i].w1_en; rf.w1_addr_i = vecs[i].w1_addr; rf.w1_data_i = vecs[i].w1_data;
      rf.issue_i = vecs[i].issue; rf.issue_rd_i = vecs[i].issue_rd;
      rf.rs1_addr_i = vecs[i].rs1; rf.rs2_addr_i = vecs[i].rs2;
      @(posedge clk);
      #1;
      idle();
      #1;
      check_reads($sformatf("vec%0d", i), vecs[i].exp_rs1, vecs[i].exp_rs2,
                  vecs[i].exp_b1, vecs[i].exp_b2, vecs[i].exp_cnt);
    end

    // Same-cycle visibility of writes and busy clear
    @(negedge clk);
    rf.issue_i = 1'b1; rf.issue_rd_i = 5'd6;
    @(posedge clk);
    #1;
    idle();
    rf.rs2_addr_i = 5'd6;
    #1;
    check("issue6 busy", {31'b0, rf.rs2_busy_o}, 32'h1);
    check("issue6 cnt", {26'b0, rf.busy_cnt_o}, 32'h1);
    @(negedge clk);
    rf.w0_en_i = 1'b1; rf.w0_addr_i = 5'd5; rf.w0_data_i = 32'hCAFEF00D;
    rf.w1_en_i = 1'b1; rf.w1_addr_i = 5'd6; rf.w1_data_i = 32'h12345678;
    rf.rs1_addr_i = 5'd5; rf.rs2_addr_i = 5'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same-cycle rs1", rf.rs1_data_o, 32'hCAFEF00D);
    check("same-cycle rs2", rf.rs2_data_o, 32'h12345678);
    check("same-cycle busy", {31'b0, rf.rs2_busy_o}, 32'h0);
`else
    check("same-cycle rs1", rf.rs1_data_o, 32'hDEADBEEF);
    check("same-cycle rs2", rf.rs2_data_o, 32'h0);
    check("same-cycle busy", {31'b0, rf.rs2_busy_o}, 32'h1);
`endif
    @(posedge clk);
    #1;
    idle();
    #1;
    check_reads("after-edge", 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b0, 6'd0);

    // Fill the scoreboard, then drain it
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      rf.issue_i = 1'b1; rf.issue_rd_i = 5'(r);
      @(posedge clk);
      #1;
      check($sformatf("fill cnt r%0d", r), {26'b0, rf.busy_cnt_o}, r);
    end
    idle();
    rf.rs1_addr_i = 5'd31; rf.rs2_addr_i = 5'd1;
    #1;
    check("full busy31", {31'b0, rf.rs1_busy_o}, 32'h1);
    check("full busy1", {31'b0, rf.rs2_busy_o}, 32'h1);
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      rf.w1_en_i = 1'b1; rf.w1_addr_i = 5'(r); rf.w1_data_i = 32'h100 + r;
      @(posedge clk);
      #1;
      check($sformatf("drain cnt r%0d", r), {26'b0, rf.busy_cnt_o}, 31 - r);
    end
    // W1 to an idle register must not underflow
    @(negedge clk);
    rf.w1_en_i = 1'b1; rf.w1_addr_i = 5'd5; rf.w1_data_i = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    idle();
    rf.rs1_addr_i = 5'd5;
    #1;
    check("no-wrap cnt", {26'b0, rf.busy_cnt_o}, 32'h0);
    check("no-wrap data", rf.rs1_data_o, 32'h5A5A5A5A);
    check("no-wrap busy", {31'b0, rf.rs1_busy_o}, 32'h0);

    // Asynchronous reset mid-sequence
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      rf.issue_i = 1'b1; rf.issue_rd_i = 5'(r);
    end
    @(posedge clk);
    #1;
    rf.rs1_addr_i = 5'd5; rf.rs2_addr_i = 5'd3;
    #1;
    check("pre-reset cnt", {26'b0, rf.busy_cnt_o}, 32'h5);
    #1;
    rst = 1'b1;
    #1;
    check_reads("async-reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reads("post-reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
